// File: rtl/qbv_rx_traffic_classifier_pkg.sv
// Shared types, constants and the frame classification rule for the
// Qbv RX traffic classifier.
package qbv_rx_traffic_classifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_STREAM,
        ST_DRAIN,
        ST_DISCARD
    } state_t;

    typedef enum logic {
        CLASS_LEGACY = 1'b0,
        CLASS_BV     = 1'b1
    } class_t;

    localparam logic [15:0]  ETH_TPID_VLAN        = 16'h8100;
    localparam int unsigned  HDR_LEN_DEFAULT      = 15;
    localparam logic [15:0]  BV_ETHERTYPE_DEFAULT = 16'h88F7;
    localparam logic [2:0]   BV_PCP_MIN_DEFAULT   = 3'd5;

    // len counts the bytes seen so far including the current one.
    // b14 >= {pcp_min, 5'b0} is the same test as b14[7:5] >= pcp_min.
    function automatic class_t classify_frame(
        input logic [4:0]  len,
        input logic [7:0]  b12,
        input logic [7:0]  b13,
        input logic [7:0]  b14,
        input logic [2:0]  pcp_min,
        input logic [15:0] bv_ethertype
    );
        class_t cls;
        cls = CLASS_LEGACY;
        if (len >= 5'd14) begin
            if ((len >= 5'd15) && ({b12, b13} == ETH_TPID_VLAN) && (b14 >= {pcp_min, 5'b0}))
                cls = CLASS_BV;
            else if ({b12, b13} == bv_ethertype)
                cls = CLASS_BV;
        end
        return cls;
    endfunction

endpackage

// File: rtl/qbv_rx_traffic_classifier_if.sv
// Byte-wide AXI-Stream bundle without tready, used for the MAC RX input
// and both per-class outputs.
interface qbv_rx_traffic_classifier_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser);
    modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/qbv_rx_traffic_classifier_hdr_buffer.sv
// 16-entry circular byte buffer holding the frame header; taps expose
// bytes 12..14 counted from the oldest byte still held.
module qbv_rx_hdr_buffer (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic [4:0] count,
    output logic [7:0] tap12,
    output logic [7:0] tap13,
    output logic [7:0] tap14
);

    logic [7:0] mem [16];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [3:0] ptr12;
    logic [3:0] ptr13;
    logic [3:0] ptr14;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 4'd1;
            if (pop)
                rd_ptr <= rd_ptr + 4'd1;
            if (push && !pop)
                count <= count + 5'd1;
            else if (pop && !push)
                count <= count - 5'd1;
        end
    end

    // Taps are only meaningful before the first pop of a frame, when the
    // read pointer still sits on byte 0.
    assign ptr12    = rd_ptr + 4'd12;
    assign ptr13    = rd_ptr + 4'd13;
    assign ptr14    = rd_ptr + 4'd14;
    assign pop_data = mem[rd_ptr];
    assign tap12    = mem[ptr12];
    assign tap13    = mem[ptr13];
    assign tap14    = mem[ptr14];

endmodule

// File: rtl/qbv_rx_traffic_classifier.sv
// Splits the MAC RX byte stream into BV and legacy streams after classifying
// each frame from its header, with per-class frame counters.
module qbv_rx_traffic_classifier
    import qbv_rx_traffic_classifier_pkg::*;
#(
    parameter int unsigned HDR_LEN      = HDR_LEN_DEFAULT,
    parameter logic [2:0]  BV_PCP_MIN   = BV_PCP_MIN_DEFAULT,
    parameter logic [15:0] BV_ETHERTYPE = BV_ETHERTYPE_DEFAULT
) (
    input  logic                          rx_mac_aclk,
    input  logic                          rx_reset,
    qbv_rx_traffic_classifier_if.slave    rx_axis_mac,
    qbv_rx_traffic_classifier_if.master   rx_axis_mac_bv,
    qbv_rx_traffic_classifier_if.master   rx_axis_mac_legacy,
    output logic [31:0]                   bv_frame_count,
    output logic [31:0]                   legacy_frame_count,
    output logic [31:0]                   drop_frame_count
);

    localparam logic [4:0] LAST_HDR_IDX = 5'(HDR_LEN - 1);

    state_t     state;
    state_t     state_next;
    class_t     cls_q;
    class_t     cls_calc;
    class_t     emit_cls;
    logic       tuser_q;
    logic       ovr_open;
    logic       ovr_open_next;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_user;

    logic       push;
    logic       pop;
    logic [7:0] pop_data;
    logic [4:0] count;
    logic [4:0] len_now;
    logic [7:0] tap12;
    logic [7:0] tap13;
    logic [7:0] tap14;
    logic [7:0] b13;
    logic [7:0] b14;

    logic       emit;
    logic [7:0] emit_data;
    logic       emit_last;
    logic       emit_user;
    logic       cls_latch;
    logic       tuser_cap;
    logic       drop_inc;

    logic [7:0] bv_tdata;
    logic       bv_tvalid;
    logic       bv_tlast;
    logic       bv_tuser;
    logic [7:0] lg_tdata;
    logic       lg_tvalid;
    logic       lg_tlast;
    logic       lg_tuser;

    assign in_data  = rx_axis_mac.tdata;
    assign in_valid = rx_axis_mac.tvalid;
    assign in_last  = rx_axis_mac.tlast;
    assign in_user  = rx_axis_mac.tuser;

    qbv_rx_hdr_buffer u_hdr_buffer (
        .clk       (rx_mac_aclk),
        .rst       (rx_reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (count),
        .tap12     (tap12),
        .tap13     (tap13),
        .tap14     (tap14)
    );

    // The deciding beat's own byte is not in the buffer yet, so bypass it.
    assign len_now  = count + 5'd1;
    assign b13      = (count == 5'd13) ? in_data : tap13;
    assign b14      = (count == 5'd14) ? in_data : tap14;
    assign cls_calc = classify_frame(len_now, tap12, b13, b14, BV_PCP_MIN, BV_ETHERTYPE);

    always_ff @(posedge rx_mac_aclk) begin
        if (rx_reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        push          = 1'b0;
        pop           = 1'b0;
        emit          = 1'b0;
        emit_data     = pop_data;
        emit_last     = 1'b0;
        emit_user     = 1'b0;
        emit_cls      = cls_q;
        cls_latch     = 1'b0;
        tuser_cap     = 1'b0;
        drop_inc      = 1'b0;
        ovr_open_next = ovr_open;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_last) begin
                        emit       = 1'b1;
                        emit_data  = in_data;
                        emit_last  = 1'b1;
                        emit_user  = in_user;
                        emit_cls   = cls_calc;
                        cls_latch  = 1'b1;
                        state_next = ST_DRAIN;
                    end else begin
                        push       = 1'b1;
                        state_next = ST_HEADER;
                    end
                end
            end

            // The deciding beat pops byte 0 so it leaves on the next cycle.
            ST_HEADER: begin
                if (in_valid) begin
                    push = 1'b1;
                    if (in_last || (count == LAST_HDR_IDX)) begin
                        pop        = 1'b1;
                        emit       = 1'b1;
                        emit_cls   = cls_calc;
                        cls_latch  = 1'b1;
                        tuser_cap  = in_last;
                        state_next = in_last ? ST_DRAIN : ST_STREAM;
                    end
                end
            end

            ST_STREAM: begin
                if (in_valid) begin
                    push      = 1'b1;
                    pop       = 1'b1;
                    emit      = 1'b1;
                    tuser_cap = in_last;
                    if (in_last)
                        state_next = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (count != 5'd0) begin
                    pop  = 1'b1;
                    emit = 1'b1;
                    if (count == 5'd1) begin
                        emit_last = 1'b1;
                        emit_user = tuser_q;
                    end
                end
                if (in_valid) begin
                    if (!ovr_open)
                        drop_inc = 1'b1;
                    ovr_open_next = !in_last;
                end
                if (count <= 5'd1) begin
                    state_next    = ovr_open_next ? ST_DISCARD : ST_IDLE;
                    ovr_open_next = 1'b0;
                end
            end

            ST_DISCARD: begin
                if (in_valid && in_last)
                    state_next = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rx_mac_aclk) begin
        if (rx_reset) begin
            cls_q              <= CLASS_LEGACY;
            tuser_q            <= 1'b0;
            ovr_open           <= 1'b0;
            bv_tdata           <= '0;
            bv_tvalid          <= 1'b0;
            bv_tlast           <= 1'b0;
            bv_tuser           <= 1'b0;
            lg_tdata           <= '0;
            lg_tvalid          <= 1'b0;
            lg_tlast           <= 1'b0;
            lg_tuser           <= 1'b0;
            bv_frame_count     <= '0;
            legacy_frame_count <= '0;
            drop_frame_count   <= '0;
        end else begin
            ovr_open <= ovr_open_next;
            if (cls_latch)
                cls_q <= emit_cls;
            if (tuser_cap)
                tuser_q <= in_user;

            bv_tdata  <= '0;
            bv_tvalid <= 1'b0;
            bv_tlast  <= 1'b0;
            bv_tuser  <= 1'b0;
            lg_tdata  <= '0;
            lg_tvalid <= 1'b0;
            lg_tlast  <= 1'b0;
            lg_tuser  <= 1'b0;
            if (emit) begin
                if (emit_cls == CLASS_BV) begin
                    bv_tdata  <= emit_data;
                    bv_tvalid <= 1'b1;
                    bv_tlast  <= emit_last;
                    bv_tuser  <= emit_user;
                end else begin
                    lg_tdata  <= emit_data;
                    lg_tvalid <= 1'b1;
                    lg_tlast  <= emit_last;
                    lg_tuser  <= emit_user;
                end
            end

            if (emit && emit_last) begin
                if (emit_cls == CLASS_BV)
                    bv_frame_count <= bv_frame_count + 32'd1;
                else
                    legacy_frame_count <= legacy_frame_count + 32'd1;
            end
            if (drop_inc)
                drop_frame_count <= drop_frame_count + 32'd1;
        end
    end

    assign rx_axis_mac_bv.tdata      = bv_tdata;
    assign rx_axis_mac_bv.tvalid     = bv_tvalid;
    assign rx_axis_mac_bv.tlast      = bv_tlast;
    assign rx_axis_mac_bv.tuser      = bv_tuser;
    assign rx_axis_mac_legacy.tdata  = lg_tdata;
    assign rx_axis_mac_legacy.tvalid = lg_tvalid;
    assign rx_axis_mac_legacy.tlast  = lg_tlast;
    assign rx_axis_mac_legacy.tuser  = lg_tuser;

endmodule
